// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: shared state encoding and AXI constants for the GPIO pattern sequencer.
package gpio_seq_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, RESP, HOLD, DONE} state_t;
   localparam logic [1:0]   RESP_OKAY   = 2'b00;
   localparam logic [1:0]   RESP_SLVERR = 2'b10;
   localparam logic [127:0] STRB_FULL   = '1;
endpackage

// File: rtl/gpio_seq_if.sv
// gpio_seq_if: AXI-Lite write channels (AW/W/B) between the sequencer and the axi_gpio slave.
interface gpio_seq_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
   logic                    m_axi_awvalid;
   logic                    m_axi_awready;
   logic [DATA_WIDTH-1:0]   m_axi_wdata;
   logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
   logic                    m_axi_wvalid;
   logic                    m_axi_wready;
   logic [1:0]              m_axi_bresp;
   logic                    m_axi_bvalid;
   logic                    m_axi_bready;
   modport master (
      output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
      input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
   );
   modport slave (
      input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
      output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
   );
endinterface

// File: rtl/gpio_seq_ctrl_table.sv
// gpio_seq_table: pattern register file, synchronous write and combinational read; not reset.
module gpio_seq_table #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 32
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   always_ff @(posedge clk)
      if (we) r_mem[waddr] <= wdata;
   assign rdata = r_mem[raddr];
endmodule

// File: rtl/gpio_seq_ctrl.sv
// gpio_seq_ctrl: AXI-Lite write master that plays a pattern table into the axi_gpio output register.
// Optional transaction timeout is enabled by defining GPIO_SEQ_TIMEOUT_EN.
module gpio_seq_ctrl
   import gpio_seq_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 8,
   parameter logic [ADDR_WIDTH-1:0] GPIO_ADDR  = '0,
   parameter int                    CNT_WIDTH  = 16
`ifdef GPIO_SEQ_TIMEOUT_EN
   , parameter int                  TIMEOUT_CYCLES = 1024
`endif
)(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
   input  logic [DATA_WIDTH-1:0]      cfg_data,
   input  logic [$clog2(DEPTH):0]     cfg_len,
   input  logic [CNT_WIDTH-1:0]       cfg_hold,
   input  logic                       cfg_loop,
   input  logic                       start,
   input  logic                       stop,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
`ifdef GPIO_SEQ_TIMEOUT_EN
   output logic                       timeout,
`endif
   gpio_seq_if.master                 m_axi
);
   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;
   state_t                r_state, w_state_nx;
   logic [IW-1:0]         r_idx, w_idx_nx;
   logic [LW-1:0]         r_len;
   logic [CNT_WIDTH-1:0]  r_hold, r_cnt;
   logic [DATA_WIDTH-1:0] r_wdata, w_rdata;
   logic                  r_loop, r_stop, r_aw_ok, r_w_ok, r_err, r_zdone;
   logic                  w_busy, w_go, w_aw_hs, w_w_hs, w_stop, w_last, w_to_hit;
   assign w_busy  = r_state == ISSUE || r_state == RESP || r_state == HOLD;
   assign w_go    = r_state == IDLE && start && cfg_len != '0;
   assign w_aw_hs = m_axi.m_axi_awvalid && m_axi.m_axi_awready;
   assign w_w_hs  = m_axi.m_axi_wvalid && m_axi.m_axi_wready;
   assign w_stop  = r_stop || stop;
   assign w_last  = LW'(r_idx) + LW'(1) == r_len;
   gpio_seq_table #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_table (
      .clk   (clk),
      .we    (cfg_we && !w_busy),
      .waddr (cfg_idx),
      .wdata (cfg_data),
      .raddr (w_idx_nx),
      .rdata (w_rdata)
   );
`ifdef GPIO_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to;
   logic          r_timeout;
   assign w_to_hit = (r_state == ISSUE || r_state == RESP) && r_to == TW'(TIMEOUT_CYCLES);
   assign timeout  = r_timeout;
   // Counts the whole ISSUE+RESP span of one entry; HOLD/IDLE clear it.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_to      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_to      <= (r_state == ISSUE || r_state == RESP) ? r_to + 1'b1 : '0;
         r_timeout <= w_go ? 1'b0 : r_timeout || w_to_hit;
      end
`else
   assign w_to_hit = 1'b0;
`endif
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nx;
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      case (r_state)
         IDLE:    if (w_go) begin
                     w_state_nx = ISSUE;
                     w_idx_nx   = '0;
                  end
         ISSUE:   if ((r_aw_ok || w_aw_hs) && (r_w_ok || w_w_hs)) w_state_nx = RESP;
         RESP:    if (m_axi.m_axi_bvalid) w_state_nx = w_stop ? DONE : HOLD;
         HOLD:    if (r_cnt == '0) begin
                     w_state_nx = (w_stop || (w_last && !r_loop)) ? DONE : ISSUE;
                     w_idx_nx   = w_last ? '0 : r_idx + 1'b1;
                  end
         default: w_state_nx = IDLE;
      endcase
      if (w_to_hit) w_state_nx = DONE;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_idx   <= '0;
         r_len   <= '0;
         r_hold  <= '0;
         r_loop  <= 1'b0;
         r_cnt   <= '0;
         r_stop  <= 1'b0;
         r_aw_ok <= 1'b0;
         r_w_ok  <= 1'b0;
         r_err   <= 1'b0;
         r_zdone <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_idx   <= w_idx_nx;
         r_zdone <= r_state == IDLE && start && cfg_len == '0;
         r_cnt   <= r_state != HOLD ? r_hold : r_cnt == '0 ? r_cnt : r_cnt - 1'b1;
         r_aw_ok <= r_state == ISSUE && (r_aw_ok || w_aw_hs);
         r_w_ok  <= r_state == ISSUE && (r_w_ok || w_w_hs);
         r_stop  <= w_busy && (r_stop || stop);
         // Pattern is captured on ISSUE entry so wdata is stable while wvalid is high.
         if (w_state_nx == ISSUE && r_state != ISSUE) r_wdata <= w_rdata;
         if (w_go) begin
            r_len  <= cfg_len > LW'(DEPTH) ? LW'(DEPTH) : cfg_len;
            r_hold <= cfg_hold;
            r_loop <= cfg_loop;
            r_err  <= 1'b0;
         end else if (r_state == RESP && m_axi.m_axi_bvalid && m_axi.m_axi_bresp != RESP_OKAY) begin
            r_err  <= 1'b1;
         end
      end
   assign busy                = w_busy;
   assign done                = r_zdone || r_state == DONE;
   assign err                 = r_err;
   assign m_axi.m_axi_awaddr  = GPIO_ADDR;
   assign m_axi.m_axi_awvalid = r_state == ISSUE && !r_aw_ok;
   assign m_axi.m_axi_wvalid  = r_state == ISSUE && !r_w_ok;
   assign m_axi.m_axi_wdata   = r_wdata;
   assign m_axi.m_axi_wstrb   = STRB_FULL[DATA_WIDTH/8-1:0];
   assign m_axi.m_axi_bready  = r_state == RESP;
endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// tb_gpio_seq_ctrl: directed tests for gpio_seq_ctrl against a behavioural AXI-Lite write slave.
module tb_gpio_seq_ctrl;
   import gpio_seq_pkg::*;
   logic        clk = 1'b0;
   logic        resetn, cfg_we, cfg_loop, start, stop, busy, done, err;
   logic [2:0]  cfg_idx;
   logic [31:0] cfg_data;
   logic [3:0]  cfg_len;
   logic [15:0] cfg_hold;
`ifdef GPIO_SEQ_TIMEOUT_EN
   logic        timeout;
`endif
   int checks = 0, errors = 0;
   int aw_n, w_n, b_n, done_cnt, viol, cyc, aw_c, w_c;
   int aw_dly = 0, w_dly = 0, err_idx = -1;
   bit b_never = 0, aw_pend, w_pend, ok;
   logic [31:0] w_prev;
   logic [31:0] wd[$];
   int          wt[$];
   always #5 clk = ~clk;
   gpio_seq_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) m ();
   gpio_seq_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(8), .GPIO_ADDR(12'h000), .CNT_WIDTH(16)) dut (
      .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
      .cfg_len(cfg_len), .cfg_hold(cfg_hold), .cfg_loop(cfg_loop), .start(start), .stop(stop),
      .busy(busy), .done(done), .err(err),
`ifdef GPIO_SEQ_TIMEOUT_EN
      .timeout(timeout),
`endif
      .m_axi(m)
   );
   // Slave and monitor: outputs change on negedge, so every handshake seen here completes at the next posedge.
   initial begin
      m.m_axi_awready = 0; m.m_axi_wready = 0; m.m_axi_bvalid = 0; m.m_axi_bresp = 2'b00;
      cyc = 0; aw_c = 0; w_c = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!m.m_axi_awvalid) begin m.m_axi_awready = 0; aw_c = 0; end
         else begin m.m_axi_awready = aw_c >= aw_dly; aw_c++; end
         if (!m.m_axi_wvalid) begin m.m_axi_wready = 0; w_c = 0; end
         else begin m.m_axi_wready = w_c >= w_dly; w_c++; end
         m.m_axi_bvalid = !b_never && aw_n > b_n && w_n > b_n;
         m.m_axi_bresp  = b_n == err_idx ? RESP_SLVERR : RESP_OKAY;
         if (aw_pend && !m.m_axi_awvalid) viol++;
         if (w_pend && (!m.m_axi_wvalid || m.m_axi_wdata !== w_prev)) viol++;
         aw_pend = m.m_axi_awvalid && !m.m_axi_awready;
         w_pend  = m.m_axi_wvalid && !m.m_axi_wready;
         w_prev  = m.m_axi_wdata;
         if (m.m_axi_awvalid && m.m_axi_awready) begin aw_n++; if (m.m_axi_awaddr !== 12'h000) viol++; end
         if (m.m_axi_wvalid && m.m_axi_wready) begin
            w_n++; wd.push_back(m.m_axi_wdata); wt.push_back(cyc);
            if (m.m_axi_wstrb !== 4'hF) viol++;
         end
         if (m.m_axi_bvalid && m.m_axi_bready) b_n++;
         if (done) done_cnt++;
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic clr();
      aw_n = 0; w_n = 0; b_n = 0; done_cnt = 0; viol = 0; aw_pend = 0; w_pend = 0;
      wd.delete(); wt.delete();
   endtask
   task automatic load(input logic [2:0] i, input logic [31:0] d);
      cfg_we = 1; cfg_idx = i; cfg_data = d; tick(); cfg_we = 0;
   endtask
   task automatic run(input logic [3:0] len, input logic [15:0] hold, input bit lp);
      cfg_len = len; cfg_hold = hold; cfg_loop = lp; start = 1; tick(); start = 0;
   endtask
   task automatic wait_done(input int lim, output bit got);
      got = 0;
      for (int i = 0; i < lim; i++) begin
         tick();
         if (done_cnt != 0) begin got = 1; break; end
      end
   endtask
   task automatic test_reset();
      resetn = 0; cfg_we = 0; cfg_idx = 0; cfg_data = 0; cfg_len = 0; cfg_hold = 0; cfg_loop = 0; start = 0; stop = 0;
      clr();
      repeat (3) tick();
      resetn = 1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (m.m_axi_awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b want 0", m.m_axi_awvalid); end
      checks++; if (m.m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", m.m_axi_wvalid); end
      checks++; if (m.m_axi_bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b want 0", m.m_axi_bready); end
      checks++; if (m.m_axi_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", m.m_axi_wdata); end
      checks++; if (m.m_axi_awaddr !== 12'h000) begin errors++; $display("FAIL reset_awaddr: got %h want 000", m.m_axi_awaddr); end
      checks++; if (m.m_axi_wstrb !== 4'hF) begin errors++; $display("FAIL reset_wstrb: got %h want F", m.m_axi_wstrb); end
   endtask
   task automatic test_basic();
      load(0, 32'hAAAA5555); load(1, 32'h5555AAAA); load(2, 32'hFFFF0000);
      clr(); run(3, 4, 0); wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done want done"); end
      checks++; if (w_n !== 3) begin errors++; $display("FAIL basic_writes: got %0d want 3", w_n); end
      checks++; if (wd[0] !== 32'hAAAA5555) begin errors++; $display("FAIL basic_wd0: got %h want AAAA5555", wd[0]); end
      checks++; if (wd[1] !== 32'h5555AAAA) begin errors++; $display("FAIL basic_wd1: got %h want 5555AAAA", wd[1]); end
      checks++; if (wd[2] !== 32'hFFFF0000) begin errors++; $display("FAIL basic_wd2: got %h want FFFF0000", wd[2]); end
      checks++; if (wt[1] - wt[0] !== 7) begin errors++; $display("FAIL basic_gap01: got %0d want 7", wt[1] - wt[0]); end
      checks++; if (wt[2] - wt[1] !== 7) begin errors++; $display("FAIL basic_gap12: got %0d want 7", wt[2] - wt[1]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL basic_protocol: got %0d violations want 0", viol); end
      repeat (3) tick();
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
   endtask
   task automatic test_handshake_order();
      for (int k = 0; k < 2; k++) begin
         aw_dly = k == 1 ? 3 : 0; w_dly = k == 1 ? 0 : 3;
         clr(); run(2, 0, 0); wait_done(100, ok);
         checks++; if (!ok) begin errors++; $display("FAIL order%0d_done_timeout: got no done want done", k); end
         checks++; if (aw_n !== 2) begin errors++; $display("FAIL order%0d_aw: got %0d want 2", k, aw_n); end
         checks++; if (w_n !== 2) begin errors++; $display("FAIL order%0d_w: got %0d want 2", k, w_n); end
         checks++; if (wd[1] !== 32'h5555AAAA) begin errors++; $display("FAIL order%0d_wd1: got %h want 5555AAAA", k, wd[1]); end
         checks++; if (wt[1] - wt[0] !== 6) begin errors++; $display("FAIL order%0d_gap: got %0d want 6", k, wt[1] - wt[0]); end
         checks++; if (viol !== 0) begin errors++; $display("FAIL order%0d_protocol: got %0d violations want 0", k, viol); end
      end
      aw_dly = 0; w_dly = 0;
   endtask
   task automatic test_bresp_err();
      clr(); err_idx = 1; run(3, 0, 0); wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL berr_done_timeout: got no done want done"); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL berr_sticky: got %b want 1", err); end
      checks++; if (w_n !== 3) begin errors++; $display("FAIL berr_writes: got %0d want 3", w_n); end
      checks++; if (b_n !== 3) begin errors++; $display("FAIL berr_resps: got %0d want 3", b_n); end
      checks++; if (wd[2] !== 32'hFFFF0000) begin errors++; $display("FAIL berr_wd2: got %h want FFFF0000", wd[2]); end
      err_idx = -1; clr(); run(1, 0, 0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL berr_clear_on_start: got %b want 0", err); end
      wait_done(100, ok);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL berr_clean_run: got %b want 0", err); end
   endtask
   task automatic test_stop();
      load(0, 32'h000000F0); load(1, 32'h0000000F);
      clr(); run(2, 0, 1);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (m.m_axi_awvalid && w_n == 1) begin ok = 1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL stop_entry1_timeout: got no entry-1 ISSUE want ISSUE"); end
      stop = 1; tick(); stop = 0;
      wait_done(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stop_done_timeout: got no done want done"); end
      repeat (10) tick();
      checks++; if (aw_n !== 2) begin errors++; $display("FAIL stop_aw: got %0d want 2", aw_n); end
      checks++; if (b_n !== 2) begin errors++; $display("FAIL stop_b: got %0d want 2", b_n); end
      checks++; if (wd[1] !== 32'h0000000F) begin errors++; $display("FAIL stop_wd1: got %h want 0000000F", wd[1]); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stop_done_pulses: got %0d want 1", done_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy); end
   endtask
   task automatic test_len_zero();
      clr(); run(0, 0, 0);
      repeat (5) tick();
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL len0_done_pulses: got %0d want 1", done_cnt); end
      checks++; if (aw_n !== 0) begin errors++; $display("FAIL len0_aw: got %0d want 0", aw_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy); end
   endtask
   task automatic test_we_busy();
      load(0, 32'hCAFE0001);
      clr(); run(1, 20, 0); tick(); tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL webusy_busy: got %b want 1", busy); end
      load(0, 32'hDEAD0000);
      wait_done(100, ok);
      checks++; if (wd[0] !== 32'hCAFE0001) begin errors++; $display("FAIL webusy_run1: got %h want CAFE0001", wd[0]); end
      clr(); run(1, 0, 0); wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL webusy_done_timeout: got no done want done"); end
      checks++; if (wd[0] !== 32'hCAFE0001) begin errors++; $display("FAIL webusy_run2: got %h want CAFE0001", wd[0]); end
   endtask
   task automatic test_clamp();
      for (int i = 0; i < 8; i++) load(3'(i), 32'h10000000 + 32'(i));
      clr(); run(12, 0, 0); wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clamp_done_timeout: got no done want done"); end
      checks++; if (w_n !== 8) begin errors++; $display("FAIL clamp_writes: got %0d want 8", w_n); end
      checks++; if (b_n !== 8) begin errors++; $display("FAIL clamp_resps: got %0d want 8", b_n); end
      checks++; if (wd[0] !== 32'h10000000) begin errors++; $display("FAIL clamp_wd0: got %h want 10000000", wd[0]); end
      checks++; if (wd[7] !== 32'h10000007) begin errors++; $display("FAIL clamp_wd7: got %h want 10000007", wd[7]); end
   endtask
   task automatic test_async_reset();
      load(0, 32'h12345678);
      clr(); w_dly = 50; run(1, 0, 0);
      ok = 0;
      for (int i = 0; i < 5; i++) begin
         if (m.m_axi_awvalid) begin ok = 1; break; end
         tick();
      end
      checks++; if (!ok) begin errors++; $display("FAIL areset_issue_timeout: got no ISSUE want ISSUE"); end
      #2 resetn = 0;
      #1;
      checks++; if (m.m_axi_awvalid !== 1'b0) begin errors++; $display("FAIL areset_awvalid: got %b want 0", m.m_axi_awvalid); end
      checks++; if (m.m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL areset_wvalid: got %b want 0", m.m_axi_wvalid); end
      checks++; if (m.m_axi_bready !== 1'b0) begin errors++; $display("FAIL areset_bready: got %b want 0", m.m_axi_bready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
      tick(); tick();
      resetn = 1; w_dly = 0;
      tick();
      clr(); run(1, 0, 0); wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL areset_restart_timeout: got no done want done"); end
      checks++; if (w_n !== 1) begin errors++; $display("FAIL areset_restart_writes: got %0d want 1", w_n); end
      checks++; if (wd[0] !== 32'h12345678) begin errors++; $display("FAIL areset_restart_wd: got %h want 12345678", wd[0]); end
   endtask
`ifdef GPIO_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int t0;
      clr(); b_never = 1; run(1, 0, 0); t0 = cyc;
      wait_done(1200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL timeout_done_timeout: got no done want done"); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout); end
      checks++; if (cyc - t0 < 1024) begin errors++; $display("FAIL timeout_early: got %0d cycles want >= 1024", cyc - t0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
      b_never = 0; clr(); run(1, 0, 0);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout); end
      wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL timeout_restart: got no done want done"); end
   endtask
`endif
   initial begin
      test_reset();
      test_basic();
      test_handshake_order();
      test_bresp_err();
      test_stop();
      test_len_zero();
      test_we_busy();
      test_clamp();
      test_async_reset();
`ifdef GPIO_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
